// File: rtl/btn_debounce_pulse.sv
// Purpose: synchronize and debounce a raw push-button into a clean level plus a one-cycle tick per press/repeat.
// Latency: 2 sync stages + 1 + STABLE_CYCLES edges from input change to db_level/tick (press tick at edge 3+STABLE_CYCLES).
// Backpressure: none; tick is a fire-and-forget enable pulse and the button input cannot be stalled.
module btn_debounce_pulse #(
    parameter int STABLE_CYCLES = 20,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_in,
    output logic       db_level,
    output logic       tick,
    output logic [1:0] state
);

    localparam int DW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    localparam bit REPEAT_EN = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {
        LOW   = 2'b00,
        WAIT1 = 2'b01,
        HIGH  = 2'b10,
        WAIT0 = 2'b11
    } st_t;

    st_t           st_q, st_d;
    logic          s1, btn_sync;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          tick_q, tick_d;

    // btn_in is asynchronous to clk; only btn_sync may feed the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            s1       <= btn_in;
            btn_sync <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= LOW;
            dcnt_q <= '0;
            rcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            dcnt_q <= dcnt_d;
            rcnt_q <= rcnt_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        dcnt_d = dcnt_q;
        rcnt_d = rcnt_q;
        tick_d = 1'b0;
        case (st_q)
            LOW: begin
                if (btn_sync) begin
                    st_d   = WAIT1;
                    dcnt_d = '0;
                end
            end
            WAIT1: begin
                if (!btn_sync) begin
                    st_d = LOW;
                end else if (dcnt_q == D_LAST) begin
                    st_d   = HIGH;
                    tick_d = 1'b1;
                    rcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    st_d   = WAIT0;
                    dcnt_d = '0;
                end else if (REPEAT_EN && (rcnt_q == R_LAST)) begin
                    tick_d = 1'b1;
                    rcnt_d = '0;
                end else if (REPEAT_EN) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            WAIT0: begin
                // A bounce back to 1 restarts the repeat spacing without a fresh tick.
                if (btn_sync) begin
                    st_d   = HIGH;
                    rcnt_d = '0;
                end else if (dcnt_q == D_LAST) begin
                    st_d = LOW;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                st_d = LOW;
            end
        endcase
    end

    assign state    = st_q;
    assign db_level = st_q[1];
    assign tick     = tick_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: one instance without repeat, one with REPEAT_CYCLES=5, both STABLE_CYCLES=4.
// A run-length reference model predicts state/db_level/tick for both instances every cycle.
module tb_btn_debounce_pulse;

    localparam int S = 4;

    logic       clk;
    logic       reset_n;
    logic       btn_in;
    logic [1:0] st0, st5;
    logic       db0, db5, tk0, tk5;
    logic [3:0] obs0, obs5;

    int checks = 0;
    int errors = 0;

    btn_debounce_pulse #(.STABLE_CYCLES(S), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .db_level(db0), .tick(tk0), .state(st0)
    );

    btn_debounce_pulse #(.STABLE_CYCLES(S), .REPEAT_CYCLES(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .db_level(db5), .tick(tk5), .state(st5)
    );

    assign obs0 = {st0, db0, tk0};
    assign obs5 = {st5, db5, tk5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted level, length of the current run of samples
    // disagreeing with it, and the edge at which the repeat phase started.
    logic       m_s1, m_s2;
    logic       m_lvl [2];
    int         m_run [2];
    int         m_t0  [2];
    logic [3:0] m_exp [2];
    int         m_t;

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        m_t  = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 1'b0;
            m_run[i] = 0;
            m_t0[i]  = 0;
            m_exp[i] = 4'b0000;
        end
    endtask

    task automatic model_edge(input logic b);
        logic v;
        logic tk;
        int   r;
        v    = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        m_t++;
        for (int i = 0; i < 2; i++) begin
            r  = (i == 0) ? 0 : 5;
            tk = 1'b0;
            if (v != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == S + 1) begin
                    m_lvl[i] = v;
                    m_run[i] = 0;
                    if (v) begin
                        tk      = 1'b1;
                        m_t0[i] = m_t;
                    end
                end
            end else begin
                if (m_lvl[i] && m_run[i] != 0)
                    m_t0[i] = m_t;
                else if (m_lvl[i] && r != 0 && ((m_t - m_t0[i]) % r) == 0)
                    tk = 1'b1;
                m_run[i] = 0;
            end
            m_exp[i] = {m_lvl[i], (m_run[i] != 0), m_lvl[i], tk};
        end
    endtask

    task automatic step(input logic b);
        btn_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        btn_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_in  = 1'b0;
        #12;
        checks++;
        if (obs0 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_d0 got=%b exp=0000", obs0);
        end
        checks++;
        if (obs5 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_d5 got=%b exp=0000", obs5);
        end
    endtask

    task automatic test_press_latency();
        logic [1:0] exp_st;
        apply_reset();
        for (int e = 1; e <= 10; e++) begin
            step(1'b1);
            exp_st = (e < 3) ? 2'b00 : (e < 7) ? 2'b01 : 2'b10;
            checks++;
            if (obs0 !== {exp_st, (e >= 7), (e == 7)}) begin
                errors++;
                $display("FAIL press_latency edge=%0d got=%b exp=%b", e, obs0, {exp_st, (e >= 7), (e == 7)});
            end
            checks++;
            if (obs5 !== m_exp[1]) begin
                errors++;
                $display("FAIL press_model_d5 edge=%0d got=%b exp=%b", e, obs5, m_exp[1]);
            end
        end
    endtask

    task automatic test_bounce();
        int e;
        apply_reset();
        e = 0;
        repeat (3) begin
            for (int k = 0; k < 4; k++) begin
                step(k < 2);
                e++;
                checks++;
                if (tk0 !== 1'b0 || db0 !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce edge=%0d got tick=%b db=%b exp tick=0 db=0", e, tk0, db0);
                end
            end
        end
        repeat (3) step(1'b0);
        checks++;
        if (obs0 !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_end got=%b exp=0000", obs0);
        end
        checks++;
        if (obs5 !== m_exp[1]) begin
            errors++;
            $display("FAIL bounce_model_d5 got=%b exp=%b", obs5, m_exp[1]);
        end
    endtask

    task automatic test_wait0_abort();
        apply_reset();
        for (int e = 1; e <= 20; e++) begin
            step((e <= 8) || (e >= 11));
            checks++;
            if (tk0 !== (e == 7) || db0 !== (e >= 7)) begin
                errors++;
                $display("FAIL wait0_abort edge=%0d got tick=%b db=%b exp tick=%b db=%b",
                         e, tk0, db0, (e == 7), (e >= 7));
            end
            if (e == 11 || e == 13) begin
                checks++;
                if (st0 !== ((e == 11) ? 2'b11 : 2'b10)) begin
                    errors++;
                    $display("FAIL wait0_state edge=%0d got=%b exp=%b", e, st0, (e == 11) ? 2'b11 : 2'b10);
                end
            end
            checks++;
            if (obs5 !== m_exp[1]) begin
                errors++;
                $display("FAIL wait0_model_d5 edge=%0d got=%b exp=%b", e, obs5, m_exp[1]);
            end
        end
    endtask

    task automatic test_repeat();
        logic exp_tk;
        logic exp_db;
        apply_reset();
        for (int e = 1; e <= 32; e++) begin
            step(e <= 20);
            exp_tk = (e == 7) || (e == 12) || (e == 17) || (e == 22);
            exp_db = (e >= 7) && (e <= 26);
            checks++;
            if (tk5 !== exp_tk || db5 !== exp_db) begin
                errors++;
                $display("FAIL repeat edge=%0d got tick=%b db=%b exp tick=%b db=%b", e, tk5, db5, exp_tk, exp_db);
            end
            checks++;
            if (tk0 !== (e == 7)) begin
                errors++;
                $display("FAIL norepeat edge=%0d got tick=%b exp tick=%b", e, tk0, (e == 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (5) step(1'b1);
        checks++;
        if (st0 !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_pre got=%b exp=01", st0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== 4'b0000 || obs5 !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async got d0=%b d5=%b exp=0000", obs0, obs5);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1'b1);
            checks++;
            if (tk0 !== (e == 7)) begin
                errors++;
                $display("FAIL reset_mid_tick edge=%0d got=%b exp=%b", e, tk0, (e == 7));
            end
            checks++;
            if (obs5 !== m_exp[1]) begin
                errors++;
                $display("FAIL reset_mid_model_d5 edge=%0d got=%b exp=%b", e, obs5, m_exp[1]);
            end
        end
    endtask

    task automatic test_counter();
        int         ticks;
        logic [2:0] cnt3;
        apply_reset();
        ticks = 0;
        cnt3  = 3'b000;
        for (int p = 0; p < 10; p++) begin
            for (int k = 0; k < 18; k++) begin
                step(k < 8);
                if (tk0 === 1'b1) begin
                    ticks++;
                    cnt3 = cnt3 + 3'd1;
                end
            end
        end
        checks++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL counter_ticks got=%0d exp=10", ticks);
        end
        checks++;
        if (cnt3 !== 3'b010) begin
            errors++;
            $display("FAIL counter_value got=%b exp=010", cnt3);
        end
    endtask

    task automatic test_random();
        logic b;
        int   left;
        int   bad;
        apply_reset();
        b    = 1'b0;
        left = 0;
        bad  = 0;
        for (int c = 0; c < 2500; c++) begin
            if (left == 0) begin
                b    = ~b;
                left = $urandom_range(1, 9);
            end
            left--;
            step(b);
            checks++;
            if (obs0 !== m_exp[0]) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_d0 cyc=%0d got=%b exp=%b", c, obs0, m_exp[0]);
            end
            checks++;
            if (obs5 !== m_exp[1]) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_d5 cyc=%0d got=%b exp=%b", c, obs5, m_exp[1]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        btn_in  = 1'b0;
        model_reset();
        test_reset();
        test_press_latency();
        test_bounce();
        test_wait0_abort();
        test_repeat();
        test_reset_mid();
        test_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Conditions a raw, bouncy, asynchronous push-button input into a clean debounced level and a single-cycle enable pulse.
- Sits directly upstream of the 3-bit enable-driven FSM counter: tick drives the counter's en, so each accepted press advances it exactly one count.
- Optional hold-to-repeat mode issues further ticks while the button stays held.

Parameters:
- STABLE_CYCLES, 20, consecutive synchronized cycles the input must hold a new value before it is accepted; legal range >= 2.
- REPEAT_CYCLES, 0, cycle spacing of auto-repeat ticks while held; 0 disables repeat; otherwise legal range >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw button, asynchronous to clk, active high.
- db_level  output  1  debounced button level.
- tick  output  1  one-cycle pulse per accepted press or repeat; connects to the counter's en.
- state  output  2  current FSM state, for debug.

Behaviour:
- Clock/reset: single clock clk. reset_n is asynchronous and active-low. All flops clear immediately on reset_n low.
- Reset values: state=LOW (2'b00), db_level=0, tick=0, both sync flops=0, both counters=0.
- Synchronizer: two-flop chain, s1<=btn_in, then btn_sync<=s1. The FSM samples only btn_sync.
- Debounce counter: dcnt, width max(1, clog2(STABLE_CYCLES)).
- Repeat counter: rcnt, width max(1, clog2(REPEAT_CYCLES)). Unused when REPEAT_CYCLES=0.
- State encoding: LOW=00, WAIT1=01, HIGH=10, WAIT0=11.
- LOW: if btn_sync=1, go to WAIT1 and set dcnt<=0; otherwise stay.
- WAIT1:
  - btn_sync=0: return to LOW, no tick.
  - btn_sync=1 and dcnt=STABLE_CYCLES-1: go to HIGH, tick<=1, rcnt<=0.
  - otherwise: dcnt<=dcnt+1.
- HIGH:
  - btn_sync=0: go to WAIT0, dcnt<=0.
  - else if REPEAT_CYCLES!=0 and rcnt=REPEAT_CYCLES-1: tick<=1, rcnt<=0.
  - else if REPEAT_CYCLES!=0: rcnt<=rcnt+1.
- WAIT0:
  - btn_sync=1: return to HIGH with rcnt<=0, no tick.
  - btn_sync=0 and dcnt=STABLE_CYCLES-1: go to LOW.
  - otherwise: dcnt<=dcnt+1.
- Release never generates a tick.
- tick is registered and is 0 in every cycle not explicitly named above. It never stays high for two consecutive cycles.
- db_level = state[1], so it is 1 in HIGH and WAIT0.
- Latency: take btn_in as high and stable from before clock edge 1.
  - btn_sync=1 after edge 2.
  - WAIT1 entered at edge 3.
  - HIGH, db_level=1 and tick=1 at edge 3+STABLE_CYCLES.
  - tick returns to 0 at the next edge.
  - Release follows the same path through WAIT0: db_level=0 at edge 3+STABLE_CYCLES after the falling input is first captured.
- Bounce: any reversal of btn_sync during a WAIT state aborts the transition. The FSM returns to its origin state and the count restarts fully on the next attempt.
- Repeat: with REPEAT_CYCLES=R, the first repeat tick comes R cycles after the press tick, then every R cycles. Ticks stop as soon as the FSM leaves HIGH.
- Reset mid-operation: the FSM returns to LOW with no tick. A button still held after reset release must go through the full debounce again before a tick is issued.
- Illegal states: none exist, since all 4 encodings are used. The next-state logic includes a default branch to LOW.

Test Plan:
- STABLE_CYCLES=4, REPEAT_CYCLES=0; btn_in 0->1 before edge 1, held -> state 01 at edge 3, tick=1 and db_level=1 at edge 7 only, tick=0 from edge 8. Counter downstream goes 0->1.
- STABLE_CYCLES=4; btn_in pulses high for 2 cycles, then 0, repeated three times (bounce) -> tick never asserts, db_level stays 0, state returns to 00.
- STABLE_CYCLES=4; press accepted, then btn_in 0 for 2 cycles and back to 1 -> WAIT0 aborts back to HIGH, db_level stays 1, no second tick.
- STABLE_CYCLES=4, REPEAT_CYCLES=5; btn_in held 20 cycles from edge 1 -> ticks at edges 7, 12, 17, 22 only. After release no further ticks, and db_level=0 four cycles after WAIT0 is entered.
- STABLE_CYCLES=4; reset_n low while in WAIT1 with dcnt=2 and btn_in held -> immediate state=00, tick=0, db_level=0. After reset release, first tick at edge 7 counted from release.
- STABLE_CYCLES=4; 10 clean presses fed to the counter -> exactly 10 ticks, counter reads 3'b010 after wrapping.
